// File: rtl/input_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// input_conditioner_pkg
// Shared constants for the pneumatic sequencer front end: default debounce
// timing, index names for the limit-switch bundle, slot index constants and
// a small edge-detect helper used by the top level.
// ---------------------------------------------------------------------------
package input_conditioner_pkg;

    // 10 ms at 50 MHz; the counter must be wide enough that it never wraps
    localparam int unsigned DEB_CYCLES_DEFAULT = 500000;
    localparam int unsigned CNT_W_DEFAULT      = 19;

    localparam int unsigned NUM_SENSORS = 4;
    localparam int unsigned NUM_SLOTS   = 4;

    // Slot reset button / output positions
    localparam logic [1:0] SLOT1 = 2'd0;
    localparam logic [1:0] SLOT2 = 2'd1;
    localparam logic [1:0] SLOT3 = 2'd2;
    localparam logic [1:0] SLOT4 = 2'd3;

    // Position of each cylinder limit switch inside the sensor bundle
    typedef enum logic [1:0] {
        SENS_A0 = 2'd0,
        SENS_A1 = 2'd1,
        SENS_B0 = 2'd2,
        SENS_B1 = 2'd3
    } sensor_idx_e;

    // One-cycle pulse when a level goes from 0 to 1
    function automatic logic risingEdge(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_ch.sv
// ---------------------------------------------------------------------------
// input_conditioner_debounce_ch
// One conditioned input channel: a 2-FF synchroniser followed by a debounce
// counter and a registered stable level. The stable level only takes a new
// value after the synchronised input has disagreed with it for DEB_CYCLES
// consecutive cycles; any shorter excursion clears the count.
//
// Ports
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   raw_i    raw, unsynchronised input
//   level_o  debounced level (RST_VAL while in reset)
// ---------------------------------------------------------------------------
module input_conditioner_debounce_ch #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 3,
    parameter logic        RST_VAL    = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o
);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             syncLevel;

    assign syncLevel = sync_q[1];

    // Count cycles of disagreement; on the last one accept the new level and
    // clear the counter, so the counter can never wrap.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (syncLevel != stable_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                stable_d = syncLevel;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser and debounce state; reset puts the whole channel at its
    // idle level so a held input after reset is treated as a fresh edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= {2{RST_VAL}};
            cnt_q    <= '0;
            stable_q <= RST_VAL;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign level_o = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
// Front end of the A+B+A-B- pneumatic sequencer. Every raw button and limit
// switch is synchronised and debounced, then turned into the levels and
// pulses that drive IN1/IN2/IN3/RESET of Slots 1..4.
//
// Ports
//   CLK                   system clock
//   RESET                 asynchronous active-low reset
//   START_BUTTON          raw start button, active-low
//   STOP_REANUDAR_BUTTON  raw stop/resume button, active-low
//   RESET_BUTTON[3:0]     raw slot reset buttons, [0]=slot1, active-low
//   a0, a1, b0, b1        raw limit switches, active-high
//   a0_c..b1_c            debounced limit-switch levels
//   START_P               one-cycle pulse on a debounced start press while RUN
//   RESET_SLOT[3:0]       debounced slot reset levels, 1 = button held
//   RUN                   1 = sequencing enabled, toggled by stop/resume
// ---------------------------------------------------------------------------
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START_BUTTON,
    input  logic       STOP_REANUDAR_BUTTON,
    input  logic [3:0] RESET_BUTTON,
    input  logic       a0,
    input  logic       a1,
    input  logic       b0,
    input  logic       b1,
    output logic       a0_c,
    output logic       a1_c,
    output logic       b0_c,
    output logic       b1_c,
    output logic       START_P,
    output logic [3:0] RESET_SLOT,
    output logic       RUN
);

    logic [NUM_SENSORS-1:0] sensRaw;
    logic [NUM_SENSORS-1:0] sensStable;
    logic [NUM_SLOTS-1:0]   slotStable;
    logic                   startStable;
    logic                   stopStable;

    logic startPressed;
    logic stopPressed;
    logic pressStart;
    logic pressStop;

    logic startPrev_q;
    logic stopPrev_q;
    logic startP_q;
    logic startP_d;
    logic run_q;
    logic run_d;

    assign sensRaw[SENS_A0] = a0;
    assign sensRaw[SENS_A1] = a1;
    assign sensRaw[SENS_B0] = b0;
    assign sensRaw[SENS_B1] = b1;

    // Limit switches idle low
    for (genvar g = 0; g < NUM_SENSORS; g++) begin : gSensor
        input_conditioner_debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W),
            .RST_VAL    (1'b0)
        ) uSensor (
            .clk_i   (CLK),
            .rst_ni  (RESET),
            .raw_i   (sensRaw[g]),
            .level_o (sensStable[g])
        );
    end

    // Buttons idle high (released)
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : gSlot
        input_conditioner_debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W),
            .RST_VAL    (1'b1)
        ) uSlot (
            .clk_i   (CLK),
            .rst_ni  (RESET),
            .raw_i   (RESET_BUTTON[g]),
            .level_o (slotStable[g])
        );
    end

    input_conditioner_debounce_ch #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W),
        .RST_VAL    (1'b1)
    ) uStart (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .raw_i   (START_BUTTON),
        .level_o (startStable)
    );

    input_conditioner_debounce_ch #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W),
        .RST_VAL    (1'b1)
    ) uStop (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .raw_i   (STOP_REANUDAR_BUTTON),
        .level_o (stopStable)
    );

    assign startPressed = ~startStable;
    assign stopPressed  = ~stopStable;
    assign pressStart   = risingEdge(startPressed, startPrev_q);
    assign pressStop    = risingEdge(stopPressed, stopPrev_q);

    // START_P is gated by the RUN value from before this cycle, so a
    // simultaneous stop press still lets the start through once.
    always_comb begin
        startP_d = pressStart & run_q;
        run_d    = run_q ^ pressStop;
    end

    // Edge history, start pulse and RUN toggle; previous-values reset to
    // "released" so a button held through reset yields exactly one pulse.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            startPrev_q <= 1'b0;
            stopPrev_q  <= 1'b0;
            startP_q    <= 1'b0;
            run_q       <= 1'b1;
        end else begin
            startPrev_q <= startPressed;
            stopPrev_q  <= stopPressed;
            startP_q    <= startP_d;
            run_q       <= run_d;
        end
    end

    assign a0_c    = sensStable[SENS_A0];
    assign a1_c    = sensStable[SENS_A1];
    assign b0_c    = sensStable[SENS_B0];
    assign b1_c    = sensStable[SENS_B1];
    assign START_P = startP_q;
    assign RUN     = run_q;

    assign RESET_SLOT[SLOT1] = ~slotStable[SLOT1];
    assign RESET_SLOT[SLOT2] = ~slotStable[SLOT2];
    assign RESET_SLOT[SLOT3] = ~slotStable[SLOT3];
    assign RESET_SLOT[SLOT4] = ~slotStable[SLOT4];

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
// Drives directed scenarios followed by random input sequences into the
// conditioner and compares every cycle's outputs against a reference model.
// Raw word layout: [0]=a0 [1]=a1 [2]=b0 [3]=b1 [4]=START [5]=STOP
// [9:6]=RESET_BUTTON[3:0].
// ---------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int DEB = 4;
    localparam logic [9:0] IDLE = 10'b11_1111_0000;

    typedef struct packed {
        logic [3:0] sens;
        logic       startP;
        logic [3:0] slot;
        logic       run;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [9:0] rawWord = IDLE;

    logic       a0_c;
    logic       a1_c;
    logic       b0_c;
    logic       b1_c;
    logic       START_P;
    logic [3:0] RESET_SLOT;
    logic       RUN;

    int vectorsApplied = 0;
    int miscompares = 0;

    exp_t expQ[$];

    // Reference model state
    logic [9:0] rawHist[$];
    logic [9:0] level;
    int         disagreeRun[10];
    logic       prevStartPressed;
    logic       prevStopPressed;
    logic       runLvl;
    logic       expStartP;

    input_conditioner #(
        .DEB_CYCLES (DEB),
        .CNT_W      (3)
    ) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .START_BUTTON         (rawWord[4]),
        .STOP_REANUDAR_BUTTON (rawWord[5]),
        .RESET_BUTTON         (rawWord[9:6]),
        .a0                   (rawWord[0]),
        .a1                   (rawWord[1]),
        .b0                   (rawWord[2]),
        .b1                   (rawWord[3]),
        .a0_c                 (a0_c),
        .a1_c                 (a1_c),
        .b0_c                 (b0_c),
        .b1_c                 (b1_c),
        .START_P              (START_P),
        .RESET_SLOT           (RESET_SLOT),
        .RUN                  (RUN)
    );

    always #5 CLK = ~CLK;

    // Reference model: each output adopts a raw level once that level, seen
    // two clocks late through the synchroniser, has differed from the output
    // for DEB consecutive cycles. Presses are 0->1 steps of the inverted
    // debounced button level.
    always @(posedge CLK) begin
        logic [9:0] seen;
        exp_t e;
        if (!RESET) begin
            rawHist          = {IDLE, IDLE};
            level            = IDLE;
            for (int c = 0; c < 10; c++) disagreeRun[c] = 0;
            prevStartPressed = 1'b0;
            prevStopPressed  = 1'b0;
            runLvl           = 1'b1;
            expStartP        = 1'b0;
        end else begin
            expStartP = !level[4] && !prevStartPressed && runLvl;
            if (!level[5] && !prevStopPressed) runLvl = !runLvl;
            prevStartPressed = !level[4];
            prevStopPressed  = !level[5];
            seen = rawHist.pop_front();
            rawHist.push_back(rawWord);
            for (int c = 0; c < 10; c++) begin
                if (seen[c] != level[c]) begin
                    disagreeRun[c]++;
                    if (disagreeRun[c] == DEB) begin
                        level[c]       = seen[c];
                        disagreeRun[c] = 0;
                    end
                end else begin
                    disagreeRun[c] = 0;
                end
            end
        end
        e.sens   = level[3:0];
        e.startP = expStartP;
        e.slot   = ~level[9:6];
        e.run    = runLvl;
        expQ.push_back(e);
    end

    task automatic checkOutput(input string name, input logic [3:0] actual,
                               input logic [3:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare on the falling edge
    always @(negedge CLK) begin
        exp_t e;
        if (expQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL queue: got empty scoreboard, expected an entry at %0t", $time);
        end else begin
            e = expQ.pop_front();
            checkOutput("sensors", {b1_c, b0_c, a1_c, a0_c}, e.sens);
            checkOutput("START_P", {3'b000, START_P}, {3'b000, e.startP});
            checkOutput("RESET_SLOT", RESET_SLOT, e.slot);
            checkOutput("RUN", {3'b000, RUN}, {3'b000, e.run});
        end
    end

    // Drive reset and raw inputs just after a falling edge, hold for n cycles
    task automatic applyStimulus(input logic rst, input logic [9:0] raw, input int n);
        @(negedge CLK);
        #1;
        RESET   = rst;
        rawWord = raw;
        repeat (n - 1) @(negedge CLK);
    endtask

    initial begin
        logic [9:0] w;
        $display("[TB] starting input_conditioner bench");

        // Reset, then a mid-count reset on a0
        applyStimulus(1'b0, IDLE, 3);
        applyStimulus(1'b1, IDLE, 5);
        applyStimulus(1'b1, IDLE | 10'b0001, 3);
        applyStimulus(1'b0, IDLE | 10'b0001, 3);
        applyStimulus(1'b1, IDLE | 10'b0001, 10);
        applyStimulus(1'b1, IDLE, 10);

        // Start held through reset release
        applyStimulus(1'b0, IDLE & ~10'b01_0000, 3);
        applyStimulus(1'b1, IDLE & ~10'b01_0000, 12);
        applyStimulus(1'b1, IDLE, 10);

        // a0 held, then a 3-cycle glitch
        applyStimulus(1'b1, IDLE | 10'b0001, 10);
        applyStimulus(1'b1, IDLE, 10);
        applyStimulus(1'b1, IDLE | 10'b0001, 3);
        applyStimulus(1'b1, IDLE, 10);

        // Start press held 20 cycles, release
        applyStimulus(1'b1, IDLE & ~10'b01_0000, 20);
        applyStimulus(1'b1, IDLE, 15);

        // Pause with stop, start ignored, resume with stop
        applyStimulus(1'b1, IDLE & ~10'b10_0000, 10);
        applyStimulus(1'b1, IDLE, 10);
        applyStimulus(1'b1, IDLE & ~10'b01_0000, 10);
        applyStimulus(1'b1, IDLE, 10);
        applyStimulus(1'b1, IDLE & ~10'b10_0000, 10);
        applyStimulus(1'b1, IDLE, 10);

        // Stop and start pressed together while running
        applyStimulus(1'b1, IDLE & ~10'b11_0000, 10);
        applyStimulus(1'b1, IDLE, 10);

        // Slot reset 1011 held, then 1-cycle bouncing, then release
        applyStimulus(1'b1, {4'b1011, 6'b11_0000}, 10);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, (i % 2 == 0) ? IDLE : {4'b1011, 6'b11_0000}, 1);
        end
        applyStimulus(1'b1, IDLE, 10);

        // Random segments, biased toward lengths around the debounce window
        for (int i = 0; i < 400; i++) begin
            w = 10'($urandom);
            if ($urandom_range(0, 2) != 0) w = IDLE ^ (10'(1) << $urandom_range(0, 9));
            applyStimulus(($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1, w,
                          $urandom_range(1, DEB + 5));
        end
        applyStimulus(1'b1, IDLE, 12);

        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
